// File: rtl/axis_accumulate_pkg.sv
// axis_accumulate_pkg: shared widths, result type and elaboration helpers for axis_accumulate
package axis_accumulate_pkg;
  localparam int MAX_ACC_W = 64;
  localparam int USER_W = 9;
  typedef struct packed {
    logic [MAX_ACC_W-1:0] sum;
    logic [USER_W-1:0]    count;
  } result_t;
  function automatic int cnt_w(input int beats);
    return $clog2(beats + 1);
  endfunction
  function automatic bit width_ok(input int td_bytes, input int beats, input int acc_bytes);
    return beats >= 2 && beats <= 256 && acc_bytes * 8 <= MAX_ACC_W &&
           acc_bytes * 8 >= td_bytes * 8 + cnt_w(beats);
  endfunction
endpackage

// File: rtl/axis_accumulate_if.sv
// axis_accumulate_if: AXI-Stream bundle; slave side carries tlast, master side carries tuser
interface axis_accumulate_if
  import axis_accumulate_pkg::*;
#(
  parameter int DATA_W = 32
) ();
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic [USER_W-1:0] tuser;
  modport master (output tvalid, tdata, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/axis_accumulate.sv
// axis_accumulate: sums groups of up to BEATS_PER_SUM beats (or until tlast) into one wide result beat
module axis_accumulate
  import axis_accumulate_pkg::*;
#(
  parameter int TDATA_WIDTH_BYTES = 4,
  parameter int BEATS_PER_SUM     = 8,
  parameter int ACC_WIDTH_BYTES   = 8
) (
  input logic              aclk,
  input logic              reset,
  axis_accumulate_if.slave  s_axis,
  axis_accumulate_if.master m_axis
);
  localparam int ACC_W = ACC_WIDTH_BYTES * 8;
  localparam int CNT_W = cnt_w(BEATS_PER_SUM);
  if (!width_ok(TDATA_WIDTH_BYTES, BEATS_PER_SUM, ACC_WIDTH_BYTES)) begin : g_bad_width
    $fatal(1, "axis_accumulate: accumulator too narrow or BEATS_PER_SUM out of range");
  end
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  result_t          r_res;
  logic             r_valid;
  logic             w_ready;
  logic             w_accept;
  logic             w_last;
  logic [ACC_W-1:0] w_sum;
  assign w_ready  = !reset && (!r_valid || m_axis.tready);
  assign w_accept = s_axis.tvalid && w_ready;
  assign w_last   = r_cnt == CNT_W'(BEATS_PER_SUM - 1) || s_axis.tlast;
  assign w_sum    = r_acc + ACC_W'(s_axis.tdata);
  assign s_axis.tready = w_ready;
  assign m_axis.tvalid = r_valid;
  assign m_axis.tdata  = r_res.sum[ACC_W-1:0];
  assign m_axis.tuser  = r_res.count;
  assign m_axis.tlast  = 1'b1;
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc <= w_last ? '0 : w_sum;
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
      // a completing beat reloads the holding register even as the old result drains
      if (w_accept && w_last) begin
        r_res   <= '{sum: MAX_ACC_W'(w_sum), count: USER_W'(r_cnt) + USER_W'(1)};
        r_valid <= 1'b1;
      end else if (m_axis.tready) begin
        r_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axis_accumulate.sv
// tb_axis_accumulate: directed and random stimulus against a group-sum reference model
module tb_axis_accumulate;
  localparam int BEATS = 4;
  logic aclk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  bit rand_mode = 0;
  bit       p_valid = 0;
  logic [63:0] p_data = '0;
  int       p_user = 0;
  logic [63:0] g_sum = '0;
  int       g_cnt = 0;
  logic [63:0] got_d[$];
  int          got_u[$];
  axis_accumulate_if #(.DATA_W(32)) s_if ();
  axis_accumulate_if #(.DATA_W(64)) m_if ();
  axis_accumulate #(
    .TDATA_WIDTH_BYTES(4),
    .BEATS_PER_SUM(BEATS),
    .ACC_WIDTH_BYTES(8)
  ) dut (
    .aclk(aclk),
    .reset(reset),
    .s_axis(s_if.slave),
    .m_axis(m_if.master)
  );
  always #5 aclk = ~aclk;
  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  always @(negedge aclk) begin
    bit er;
    if (reset) begin
      p_valid = 0; p_data = '0; p_user = 0; g_sum = '0; g_cnt = 0;
    end
    er = !reset && (!p_valid || m_if.tready);
    cmp("s_tready", 64'(s_if.tready), 64'(er));
    cmp("m_tvalid", 64'(m_if.tvalid), 64'(p_valid));
    if (reset || p_valid) begin
      cmp("m_tdata", m_if.tdata, p_data);
      cmp("m_tuser", 64'(m_if.tuser), 64'(p_user));
    end
    if (!reset) begin
      if (m_if.tvalid && m_if.tready) begin
        got_d.push_back(m_if.tdata);
        got_u.push_back(int'(m_if.tuser));
      end
      if (p_valid && m_if.tready) p_valid = 0;
      if (s_if.tvalid && er) begin
        g_sum += 64'(s_if.tdata);
        g_cnt++;
        if (g_cnt == BEATS || s_if.tlast) begin
          p_valid = 1; p_data = g_sum; p_user = g_cnt;
          g_sum = '0; g_cnt = 0;
        end
      end
    end
  end
  task automatic tick();
    @(posedge aclk);
    #1;
    if (rand_mode) m_if.tready = $urandom_range(0, 3) != 0;
  endtask
  task automatic send(input logic [31:0] d, input logic l);
    bit ok = 0;
    s_if.tvalid = 1; s_if.tdata = d; s_if.tlast = l;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge aclk);
      ok = s_if.tready;
      tick();
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: beat %0h not accepted within 200 cycles", d);
    end
  endtask
  task automatic idle(input int n);
    s_if.tvalid = 0; s_if.tlast = 0;
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic chk_got(input int idx, input logic [63:0] d, input int u);
    checks++;
    if (idx >= got_d.size()) begin
      errors++;
      $display("FAIL result_%0d_missing: got %0d results required more than %0d", idx, got_d.size(), idx);
    end else begin
      cmp($sformatf("result_%0d_data", idx), got_d[idx], d);
      cmp($sformatf("result_%0d_user", idx), 64'(got_u[idx]), 64'(u));
    end
  endtask
  task automatic clear_got();
    got_d.delete(); got_u.delete();
  endtask
  initial begin
    logic [63:0] held_d;
    int stalls;
    s_if.tvalid = 0; s_if.tdata = '0; s_if.tlast = 0; s_if.tuser = '0;
    m_if.tready = 1;
    repeat (3) @(posedge aclk);
    #1 reset = 0;
    idle(2);
    clear_got();
    for (int i = 1; i <= 4; i++) send(32'(i), 0);
    idle(3);
    chk_got(0, 64'd10, 4);
    cmp("t1_count", 64'(got_d.size()), 64'd1);
    clear_got();
    send(5, 0); send(6, 1);
    for (int i = 7; i <= 10; i++) send(32'(i), 0);
    idle(3);
    chk_got(0, 64'd11, 2);
    chk_got(1, 64'd34, 4);
    clear_got();
    repeat (4) send(32'hFFFF_FFFF, 0);
    idle(3);
    chk_got(0, 64'h3_FFFF_FFFC, 4);
    clear_got();
    m_if.tready = 0;
    repeat (4) send(1, 0);
    s_if.tvalid = 1; s_if.tdata = 2; s_if.tlast = 1;
    held_d = m_if.tdata;
    stalls = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      if (!s_if.tready) stalls++;
      cmp("hold_tdata", m_if.tdata, 64'd4);
      @(posedge aclk);
      #1;
    end
    cmp("stall_cycles", 64'(stalls), 64'd5);
    cmp("held_before_stall", held_d, 64'd4);
    m_if.tready = 1;
    send(2, 1);
    idle(3);
    chk_got(0, 64'd4, 4);
    chk_got(1, 64'd2, 1);
    clear_got();
    repeat (12) send(1, 0);
    idle(3);
    for (int i = 0; i < 3; i++) chk_got(i, 64'd4, 4);
    clear_got();
    send(7, 0); send(7, 0);
    reset = 1;
    idle(2);
    reset = 0;
    idle(1);
    repeat (4) send(3, 0);
    idle(3);
    chk_got(0, 64'd12, 4);
    cmp("reset_count", 64'(got_d.size()), 64'd1);
    rand_mode = 1;
    for (int i = 0; i < 400; i++) begin
      send($urandom, $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_mode = 0;
    m_if.tready = 1;
    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_accumulate.md
Name: axis_accumulate

Overview:
- Downstream consumer of the two-input stream combiner's m_axis output.
- Sums groups of BEATS_PER_SUM input beats into one wider result beat. A group also ends early on s_axis_tlast.
- Emits each result with the beat count of its group.
- Single AXI-Stream in, single AXI-Stream out, full throughput (one input beat per cycle under no backpressure).

Parameters:
- TDATA_WIDTH_BYTES, 4, input tdata width in bytes; matches the upstream combiner.
- BEATS_PER_SUM, 8, nominal group length; legal range 2..256.
- ACC_WIDTH_BYTES, 8, output tdata width in bytes. Elaboration check: ACC_WIDTH_BYTES*8 >= TDATA_WIDTH_BYTES*8 + $clog2(BEATS_PER_SUM+1); $fatal otherwise.

Ports:
- aclk  in  1  clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  input beat ready.
- s_axis_tdata  in  TDATA_WIDTH_BYTES*8  unsigned operand.
- s_axis_tlast  in  1  closes the current group early.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  result ready.
- m_axis_tdata  out  ACC_WIDTH_BYTES*8  group sum.
- m_axis_tuser  out  9  number of beats in the group, 1..BEATS_PER_SUM.

Behaviour:
- Reset (async assert; deassertion synchronous to aclk by the integrator):
  - acc=0, cnt=0.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0.
  - s_axis_tready=0 while reset is high.
- Accept rule:
  - s_axis_tready = !m_axis_tvalid || m_axis_tready (combinational, outside reset).
  - A beat is accepted when s_axis_tvalid && s_axis_tready.
- Accepted beat is the group's last beat when cnt==BEATS_PER_SUM-1 or s_axis_tlast=1:
  - Next edge: m_axis_tdata = acc + zero-extended tdata; m_axis_tuser = cnt+1; m_axis_tvalid=1.
  - Same edge: acc=0, cnt=0.
- Accepted beat is not last: acc += zero-extended tdata; cnt += 1; output register unchanged.
- Latency: last input beat accepted at edge N gives m_axis_tvalid=1 after edge N. No combinational path from s_axis_tdata to m_axis_*.
- Output hold:
  - While m_axis_tvalid && !m_axis_tready, m_axis_tdata and m_axis_tuser are stable.
  - s_axis_tready=0 in this condition, so no input beat is accepted.
- Simultaneous events:
  - Output handshake completes and a new last beat is accepted on the same edge: the output register reloads with the new result; m_axis_tvalid stays 1.
  - Output handshake completes with no new last beat: m_axis_tvalid goes to 0.
- Backpressure stalls input only while a result is pending. Accumulation of a non-completing group continues whenever s_axis_tready=1.
- Upstream must never deassert s_axis_tvalid or change data before the handshake. The block does not check this.
- No overflow is possible, guaranteed by the elaboration check.
- Reset mid-group: a partial sum is discarded and a pending output is dropped. The first beat after reset starts a fresh group.
- s_axis_tlast on beat 1: one-beat group, tuser=1, tdata=zero-extended input.
- tlast on beat BEATS_PER_SUM coincides with the count limit: a single group closes, not two.

Decomposition:
- Package axis_accumulate_pkg holds:
  - localparam CNT_W = $clog2(BEATS_PER_SUM+1) helper function.
  - typedef for the result struct {sum, count}.
  - width-check function used by the elaboration assertion.
- No sub-module. Counter, accumulator and output register live in one module. The output register is a plain valid/ready holding register, not a skid buffer.

Test Plan:
- BEATS_PER_SUM=4, tdata 1,2,3,4 back-to-back, m_axis_tready=1 -> one output: tdata=10, tuser=4, one cycle after 4th accept. s_axis_tready stays 1 throughout.
- Inputs 5,6 with tlast on 6, then 7,8,9,10 -> outputs (11,tuser=2) then (34,tuser=4).
- Four beats of 32'hFFFF_FFFF, BEATS_PER_SUM=4 -> tdata=64'h3_FFFF_FFFC, tuser=4. No truncation.
- Result pending with m_axis_tready=0 for 5 cycles -> s_axis_tready=0 for those 5 cycles; m_axis_tdata/tuser stable. Then tready=1 -> handshake, input resumes the same cycle.
- Continuous 12 beats of value 1, m_axis_tready=1 -> three outputs of 4, each tuser=4. No bubble at group boundaries.
- Reset asserted after 2 accepted beats of group, then 4 beats of 3 -> single output 12, tuser=4. m_axis_tvalid=0 during reset.
